// File: rtl/eth_rx_pkt_fifo_pkg.sv
// -----------------------------------------------------------------------------
// eth_rx_pkt_fifo_pkg
//   Shared types for the receive-side store-and-forward packet FIFO.
//   - wr_state_t : write-side FSM states
//   - entry_t    : one buffered beat {last, len, data} at the default
//                  16-bit payload width, for code that handles entries
//                  outside the FIFO at that width.
//   The FIFO itself builds an entry of the same layout from its own
//   DATA_W/LEN_W parameters, so other widths use the same field order.
// -----------------------------------------------------------------------------
package eth_rx_pkt_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DROP  = 2'd2
  } wr_state_t;

  localparam int PKT_DATA_W  = 16;
  localparam int PKT_KEEP_W  = PKT_DATA_W / 8;
  localparam int PKT_LEN_W   = $clog2(PKT_KEEP_W + 1);
  localparam int PKT_ENTRY_W = 1 + PKT_LEN_W + PKT_DATA_W;

  typedef struct packed {
    logic                  last;
    logic [PKT_LEN_W-1:0]  len;
    logic [PKT_DATA_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/eth_rx_pkt_fifo_ram_sdp.sv
// -----------------------------------------------------------------------------
// eth_rx_pkt_fifo_ram_sdp
//   Simple dual-port RAM: one write port, one registered read port.
//   The array has no reset; read-during-write to the same address returns
//   the old contents (the FIFO never relies on that case).
// Ports:
//   clk    : clock
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address, sampled on the clock edge
//   rdata  : registered read data
// -----------------------------------------------------------------------------
module eth_rx_pkt_fifo_ram_sdp #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/eth_rx_pkt_fifo.sv
// -----------------------------------------------------------------------------
// eth_rx_pkt_fifo
//   Store-and-forward packet FIFO behind the receive stack's payload output.
//   Beats are buffered and only become readable once the packet's last beat
//   is accepted. Cancelled, restarted or overflowing packets are rolled back
//   to the last commit point so no partial payload ever reaches the output.
//
// Ports:
//   clk, nreset            : clock, synchronous active-high reset
//   valid_i/start_i/term_i : input beat valid, first beat, last beat
//   cancel_i               : abort the packet being written
//   data_i/len_i           : payload (byte 0 in LSBs), valid byte count
//   valid_o/ready_i        : registered output handshake
//   start_o/last_o         : output packet delimiters
//   data_o/len_o           : output payload and valid byte count
//   drop_cnt_o             : saturating count of packets dropped on overflow
//
// Write FSM
//   state | meaning
//   IDLE  | between packets; only a start beat opens a packet
//   WRITE | packet open, beats are being written after wr_commit
//   DROP  | packet overflowed; discard until term or a new start
// -----------------------------------------------------------------------------
module eth_rx_pkt_fifo
  import eth_rx_pkt_fifo_pkg::*;
#(
  parameter int  DATA_W = PKT_DATA_W,
  parameter int  LEN_W  = $clog2(DATA_W / 8 + 1),
  parameter int  DEPTH  = 64,
  parameter int  CNT_W  = 16,
  localparam int KEEP_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              valid_i,
  input  logic              start_i,
  input  logic              term_i,
  input  logic              cancel_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              start_o,
  output logic              last_o,
  output logic [DATA_W-1:0] data_o,
  output logic [LEN_W-1:0]  len_o,
  output logic [CNT_W-1:0]  drop_cnt_o
);

  localparam int AW      = $clog2(DEPTH);
  localparam int PW      = AW + 1;
  localparam int ENTRY_W = 1 + LEN_W + 8 * KEEP_W;
  localparam logic [PW-1:0] FULL_LVL = PW'(DEPTH);

  typedef struct packed {
    logic              last;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] data;
  } fifo_entry_t;

  wr_state_t   state;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] wr_commit;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_ptr_nxt;
  logic [PW-1:0] wr_base;
  logic        accept;
  logic        overflow;
  logic        wr_en;
  logic        load;
  logic        q_ok;
  logic        sop_next;
  fifo_entry_t wr_entry;
  fifo_entry_t rd_entry;

  // ---------------------------------------------------------------------------
  // Write decode. A start beat always writes at the commit point, which both
  // opens a packet from IDLE/DROP and discards a partial packet in WRITE.
  // Fullness is judged from that same base so a restart sees the space the
  // rollback frees.
  // ---------------------------------------------------------------------------
  always_comb begin
    accept = 1'b0;
    if (valid_i && !cancel_i) begin
      case (state)
        WRITE:   accept = 1'b1;
        default: accept = start_i;
      endcase
    end
    wr_base  = start_i ? wr_commit : wr_ptr;
    overflow = accept && ((wr_base - rd_ptr) == FULL_LVL);
    wr_en    = accept && !overflow;
    wr_entry = '{last: term_i, len: len_i, data: data_i};
  end

  always_ff @(posedge clk) begin
    if (nreset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      wr_commit  <= '0;
      drop_cnt_o <= '0;
    end else if (cancel_i) begin
      wr_ptr <= wr_commit;
      state  <= IDLE;
    end else if (overflow) begin
      wr_ptr <= wr_commit;
      state  <= DROP;
      if (drop_cnt_o != {CNT_W{1'b1}}) begin
        drop_cnt_o <= drop_cnt_o + CNT_W'(1);
      end
    end else if (wr_en) begin
      wr_ptr <= wr_base + PW'(1);
      if (term_i) begin
        wr_commit <= wr_base + PW'(1);
        state     <= IDLE;
      end else begin
        state <= WRITE;
      end
    end else if (valid_i && term_i && state == DROP) begin
      state <= IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // Read side. The RAM is addressed with the next read pointer so its output
  // always holds the entry at rd_ptr. q_ok marks that entry as committed; it
  // uses the pre-edge commit pointer, so the entry was written on an earlier
  // edge and the registered read returns real data.
  // ---------------------------------------------------------------------------
  assign load       = q_ok && (!valid_o || ready_i);
  assign rd_ptr_nxt = rd_ptr + PW'(load);

  eth_rx_pkt_fifo_ram_sdp #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_base[AW-1:0]),
    .wdata (wr_entry),
    .raddr (rd_ptr_nxt[AW-1:0]),
    .rdata (rd_entry)
  );

  always_ff @(posedge clk) begin
    if (nreset) begin
      rd_ptr   <= '0;
      q_ok     <= 1'b0;
      sop_next <= 1'b1;
      valid_o  <= 1'b0;
      start_o  <= 1'b0;
      last_o   <= 1'b0;
      data_o   <= '0;
      len_o    <= '0;
    end else begin
      rd_ptr <= rd_ptr_nxt;
      q_ok   <= (rd_ptr_nxt != wr_commit);
      if (load) begin
        valid_o  <= 1'b1;
        start_o  <= sop_next;
        last_o   <= rd_entry.last;
        data_o   <= rd_entry.data;
        len_o    <= rd_entry.len;
        // the beat after a last beat opens the next packet
        sop_next <= rd_entry.last;
      end else if (ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_eth_rx_pkt_fifo.sv
// -----------------------------------------------------------------------------
// tb_eth_rx_pkt_fifo
//   Scoreboard bench for eth_rx_pkt_fifo (DEPTH = 4, DATA_W = 16). Stimulus
//   tasks push the beats they expect to see; a negedge monitor pops and
//   compares every accepted output beat and checks hold-while-stalled.
// -----------------------------------------------------------------------------
module tb_eth_rx_pkt_fifo;
  import eth_rx_pkt_fifo_pkg::*;

  localparam int DATA_W = PKT_DATA_W;
  localparam int LEN_W  = PKT_LEN_W;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              nreset;
  logic              valid_i, start_i, term_i, cancel_i, ready_i;
  logic [DATA_W-1:0] data_i;
  logic [LEN_W-1:0]  len_i;
  logic              valid_o, start_o, last_o;
  logic [DATA_W-1:0] data_o;
  logic [LEN_W-1:0]  len_o;
  logic [CNT_W-1:0]  drop_cnt_o;

  typedef struct packed {
    logic              start;
    logic              last;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] data;
  } beat_t;

  beat_t sb[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    exp_drops = 0;

  always #5 clk = ~clk;

  eth_rx_pkt_fifo #(
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .nreset     (nreset),
    .valid_i    (valid_i),
    .start_i    (start_i),
    .term_i     (term_i),
    .cancel_i   (cancel_i),
    .data_i     (data_i),
    .len_i      (len_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .start_o    (start_o),
    .last_o     (last_o),
    .data_o     (data_o),
    .len_o      (len_o),
    .drop_cnt_o (drop_cnt_o)
  );

  // ---------------- monitor ----------------
  beat_t held;
  beat_t got;
  beat_t exp;
  logic  stall_prev = 1'b0;

  always @(negedge clk) begin
    if (nreset) begin
      stall_prev = 1'b0;
    end else begin
      got = beat_t'({start_o, last_o, len_o, data_o});
      if (stall_prev) begin
        n_cmp++;
        if (valid_o !== 1'b1 || got !== held) begin
          n_bad++;
          $display("FAIL hold_stable: got v=%0b %h, required v=1 %h", valid_o, got, held);
        end
      end
      if (valid_o && ready_i) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_beat: got %h, required no beat", got);
        end else begin
          exp = sb.pop_front();
          if (got !== exp) begin
            n_bad++;
            $display("FAIL out_beat: got sop=%0b eop=%0b len=%0d data=%h, required sop=%0b eop=%0b len=%0d data=%h",
                     got.start, got.last, got.len, got.data, exp.start, exp.last, exp.len, exp.data);
          end
        end
      end
      stall_prev = valid_o && !ready_i;
      held       = got;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic v, input logic s, input logic t, input logic c,
                       input logic [LEN_W-1:0] l, input logic [DATA_W-1:0] d);
    valid_i = v; start_i = s; term_i = t; cancel_i = c; len_i = l; data_i = d;
    @(posedge clk); #1;
    valid_i = 1'b0; start_i = 1'b0; term_i = 1'b0; cancel_i = 1'b0;
  endtask

  task automatic send_pkt(input int n, input logic [LEN_W-1:0] last_len, input bit push);
    for (int i = 0; i < n; i++) begin
      logic [DATA_W-1:0] d;
      logic [LEN_W-1:0]  l;
      d = DATA_W'($urandom);
      l = (i == n - 1) ? last_len : LEN_W'(2);
      if (push) sb.push_back('{start: (i == 0), last: (i == n - 1), len: l, data: d});
      drive(1'b1, i == 0, i == n - 1, 1'b0, l, d);
    end
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    nreset = 1'b1; ready_i = 1'b1;
    valid_i = 1'b0; start_i = 1'b0; term_i = 1'b0; cancel_i = 1'b0;
    data_i = '0; len_i = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b, required 0", valid_o); end
    n_cmp++; if (start_o !== 1'b0) begin n_bad++; $display("FAIL rst_start: got %b, required 0", start_o); end
    n_cmp++; if (last_o !== 1'b0) begin n_bad++; $display("FAIL rst_last: got %b, required 0", last_o); end
    n_cmp++; if (data_o !== '0) begin n_bad++; $display("FAIL rst_data: got %h, required 0", data_o); end
    n_cmp++; if (len_o !== '0) begin n_bad++; $display("FAIL rst_len: got %0d, required 0", len_o); end
    n_cmp++; if (drop_cnt_o !== '0) begin n_bad++; $display("FAIL rst_drop: got %0d, required 0", drop_cnt_o); end
    nreset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    ready_i = 1'b1;
    send_pkt(3, LEN_W'(1), 1'b1);
    @(posedge clk); @(negedge clk);
    n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL latency_early: got valid=%b one edge after term, required 0", valid_o); end
    @(posedge clk); @(negedge clk);
    n_cmp++; if (valid_o !== 1'b1) begin n_bad++; $display("FAIL latency: got valid=%b two edges after term, required 1", valid_o); end
    wait_drain(50);
    n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL basic_drain: got %0d left, required 0", sb.size()); end
  endtask

  task automatic test_cancel();
    ready_i = 1'b1;
    for (int i = 0; i < 3; i++) drive(1'b1, i == 0, 1'b0, 1'b0, LEN_W'(2), DATA_W'($urandom));
    drive(1'b1, 1'b0, 1'b0, 1'b1, LEN_W'(2), DATA_W'($urandom));
    repeat (3) @(posedge clk);
    #1;
    send_pkt(2, LEN_W'(2), 1'b1);
    wait_drain(50);
    n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL cancel_drain: got %0d left, required 0", sb.size()); end
    n_cmp++; if (drop_cnt_o !== CNT_W'(exp_drops)) begin n_bad++; $display("FAIL cancel_drop: got %0d, required %0d", drop_cnt_o, exp_drops); end
  endtask

  task automatic test_restart();
    logic [DATA_W-1:0] d;
    ready_i = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0, LEN_W'(2), DATA_W'($urandom));
    drive(1'b1, 1'b0, 1'b0, 1'b0, LEN_W'(2), DATA_W'($urandom));
    d = DATA_W'($urandom);
    sb.push_back('{start: 1'b1, last: 1'b1, len: LEN_W'(1), data: d});
    drive(1'b1, 1'b1, 1'b1, 1'b0, LEN_W'(1), d);
    wait_drain(50);
    n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL restart_drain: got %0d left, required 0", sb.size()); end
  endtask

  task automatic test_overflow();
    ready_i = 1'b0;
    send_pkt(3, LEN_W'(1), 1'b1);
    send_pkt(2, LEN_W'(1), 1'b0);
    exp_drops++;
    @(negedge clk);
    n_cmp++; if (drop_cnt_o !== CNT_W'(exp_drops)) begin n_bad++; $display("FAIL ovf_drop: got %0d, required %0d", drop_cnt_o, exp_drops); end
    @(posedge clk); #1;
    ready_i = 1'b1;
    wait_drain(50);
    n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL ovf_drain: got %0d left, required 0", sb.size()); end
  endtask

  task automatic test_back_to_back();
    ready_i = 1'b1;
    fork
      begin
        send_pkt(2, LEN_W'(2), 1'b1);
        send_pkt(2, LEN_W'(1), 1'b1);
      end
      begin
        repeat (30) begin
          @(posedge clk); #1;
          ready_i = ~ready_i;
        end
      end
    join
    ready_i = 1'b1;
    wait_drain(50);
    n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL b2b_drain: got %0d left, required 0", sb.size()); end
  endtask

  task automatic test_reset_mid();
    ready_i = 1'b0;
    send_pkt(2, LEN_W'(2), 1'b0);
    repeat (3) @(posedge clk);
    #1;
    drive(1'b1, 1'b1, 1'b0, 1'b0, LEN_W'(2), DATA_W'($urandom));
    nreset = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid: got %b, required 0", valid_o); end
    n_cmp++; if ({start_o, last_o, len_o, data_o} !== '0) begin n_bad++; $display("FAIL mid_rst_out: got %h, required 0", {start_o, last_o, len_o, data_o}); end
    n_cmp++; if (drop_cnt_o !== '0) begin n_bad++; $display("FAIL mid_rst_drop: got %0d, required 0", drop_cnt_o); end
    nreset = 1'b0;
    exp_drops = 0;
    ready_i = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 1'b0, LEN_W'(2), DATA_W'($urandom));
    repeat (6) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL stale_beat: got valid=%b, required 0", valid_o); end
    @(posedge clk); #1;
    send_pkt(1, LEN_W'(2), 1'b1);
    wait_drain(50);
    n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL post_rst_drain: got %0d left, required 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cancel();
    test_restart();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, required finish before 100000");
    $fatal(1);
  end

endmodule
